ucode_decode_stage: RTL and testbench
=====================================

Name: ucode_decode_stage

Overview:
- Parametrised, registered micro-instruction decode stage. It sits between the micro-sequencer fetch and the datapath execute stage.
- It unpacks a packed micro-instruction into fields and control strobes, and registers them behind a valid/ready handshake.
- It holds a per-register busy scoreboard and stalls issue on RAW or WAW hazards against writes still outstanding.
- It counts hazard-stall cycles in a saturating performance counter.

Parameters:
- TYPE_W, 3, micro-instruction type field width
- REG_W, 5, register specifier width; scoreboard depth NREGS = 2**REG_W
- IMM_W, 8, immediate field width
- BR_W, 8, micro-branch target width
- ARGS_W, 10, bus-argument field width (must be ≥9)
- CNT_W, 16, stall counter width
- Localparam MINST_W = TYPE_W+2*REG_W+IMM_W+BR_W+ARGS_W.
- Packing, MSB to LSB: type | src | dst | imm | br | args.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  micro-instruction present
- in_ready  out  1  stage accepts in_minstr this cycle
- in_minstr  in  MINST_W  packed micro-instruction
- flush  in  1  discard the registered output instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- out_type  out  TYPE_W  type field
- out_src, out_dst  out  REG_W  register specifiers
- out_imm  out  IMM_W  immediate
- out_br_target  out  BR_W  micro-branch target
- out_alu_en_a  out  1  args[0]
- out_alu_en_b  out  1  args[8]
- out_alu_op  out  3  args[3:1]
- out_rf_en  out  1  args[4]
- out_rf_rw  out  1  args[5]
- out_imm_active  out  1  type ∈ {1,2,3}
- out_is_branch  out  1  type ∈ {3,4}
- wb_valid  in  1  register write completed
- wb_reg  in  REG_W  register whose write completed
- busy_vec  out  NREGS  scoreboard state
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: out_valid=0, all out_* fields 0, busy_vec=0, stall_cnt=0. Reset overrides every other input in the same cycle, including mid-stall and mid-flush.
- Input classification (combinational on in_minstr):
  - reads_src = type != 4.
  - writes_dst = args[4] & args[5].
- hazard = in_valid & ((reads_src & busy[src]) | (writes_dst & busy[dst])).
  - busy is the registered value. There is no same-cycle bypass from wb_valid, so a clear takes effect on the next cycle.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- accept = in_valid & in_ready.
- On accept, the output register loads all decoded fields next cycle and out_valid=1. Latency is 1 cycle.
- On out_valid & out_ready & !accept, out_valid clears. Fields hold their last value.
- With out_valid=1 and out_ready=0, all out_* stay stable.
- flush: out_valid is cleared next cycle and nothing is accepted that cycle.
  - The scoreboard is not rolled back, because the busy bit was set at accept.
  - The datapath must still deliver wb for a flushed write, or software accepts a leaked busy bit.
- Scoreboard:
  - On accept & writes_dst, busy[dst] is set.
  - On wb_valid, busy[wb_reg] is cleared.
  - Same register set and cleared in the same cycle: set wins.
  - wb_valid on a non-busy register: no effect.
- stall_cnt increments on each cycle with in_valid & hazard & !flush & !rst. It saturates at all-ones.
- Cycles stalled only by back-pressure (out_ready=0) are not counted.
- Field decode is pure slicing. No sign extension. Widths exactly as parameterised.

Test Plan:
- Basic decode: with defaults, send type=1, src=3, dst=7, imm=0xA5, br=0x12, args=0x13F, out_ready=1.
  - Next cycle: out_valid=1, imm_active=1, is_branch=0, alu_en_a=1, alu_en_b=1, alu_op=7, rf_en=1, rf_rw=1.
  - busy_vec bit 7 set.
- RAW stall: follow the above with src=7, type=0. in_ready=0 and stall_cnt increments each cycle.
  - wb_valid with wb_reg=7 at cycle N: busy clears at N+1, in_ready=1 at N+1, accept at N+1, out_valid at N+2.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 and no hazard.
  - in_ready=0, outputs stable, stall_cnt unchanged.
  - Release: one transfer per cycle thereafter.
- Set/clear collision: in the same cycle, accept a write to r4 while wb_valid clears r4 → busy[4]=1 after the edge.
- Flush and reset: flush while out_valid=1 → out_valid=0 next cycle and no accept that cycle.
  - rst asserted mid-stall → all outputs 0, busy_vec=0, stall_cnt=0 after the edge.
- Saturation: with CNT_W=4, force 20 hazard cycles → stall_cnt=15, holding.
  - Branch type 4 with busy src → no stall, since it does not read src.

Source files
------------

// File: rtl/ucode_decode_stage.sv
// rtl/ucode_decode_stage.sv - registered micro-instruction decode stage with busy scoreboard
module ucode_decode_stage #(
    parameter int TYPE_W = 3,
    parameter int REG_W  = 5,
    parameter int IMM_W  = 8,
    parameter int BR_W   = 8,
    parameter int ARGS_W = 10,
    parameter int CNT_W  = 16,
    localparam int MINST_W = TYPE_W + 2*REG_W + IMM_W + BR_W + ARGS_W,
    localparam int NREGS   = 2**REG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MINST_W-1:0]   in_minstr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TYPE_W-1:0]    out_type,
    output logic [REG_W-1:0]     out_src,
    output logic [REG_W-1:0]     out_dst,
    output logic [IMM_W-1:0]     out_imm,
    output logic [BR_W-1:0]      out_br_target,
    output logic                 out_alu_en_a,
    output logic                 out_alu_en_b,
    output logic [2:0]           out_alu_op,
    output logic                 out_rf_en,
    output logic                 out_rf_rw,
    output logic                 out_imm_active,
    output logic                 out_is_branch,
    input  logic                 wb_valid,
    input  logic [REG_W-1:0]     wb_reg,
    output logic [NREGS-1:0]     busy_vec,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int BR_LO   = ARGS_W;
    localparam int IMM_LO  = BR_LO + BR_W;
    localparam int DST_LO  = IMM_LO + IMM_W;
    localparam int SRC_LO  = DST_LO + REG_W;
    localparam int TYPE_LO = SRC_LO + REG_W;

    // Field slicing of the incoming word
    logic [TYPE_W-1:0] in_type;
    logic [REG_W-1:0]  in_src;
    logic [REG_W-1:0]  in_dst;
    logic [IMM_W-1:0]  in_imm;
    logic [BR_W-1:0]   in_br;
    logic [ARGS_W-1:0] in_args;

    assign in_type = in_minstr[TYPE_LO +: TYPE_W];
    assign in_src  = in_minstr[SRC_LO  +: REG_W];
    assign in_dst  = in_minstr[DST_LO  +: REG_W];
    assign in_imm  = in_minstr[IMM_LO  +: IMM_W];
    assign in_br   = in_minstr[BR_LO   +: BR_W];
    assign in_args = in_minstr[ARGS_W-1:0];

    logic unused_args;
    assign unused_args = ^in_args;

    logic reads_src;
    logic writes_dst;
    logic in_imm_active;
    logic in_is_branch;
    logic hazard;
    logic accept;

    // Registered state
    logic               valid_q,      valid_d;
    logic [TYPE_W-1:0]  type_q,       type_d;
    logic [REG_W-1:0]   src_q,        src_d;
    logic [REG_W-1:0]   dst_q,        dst_d;
    logic [IMM_W-1:0]   imm_q,        imm_d;
    logic [BR_W-1:0]    br_q,         br_d;
    logic               alu_en_a_q,   alu_en_a_d;
    logic               alu_en_b_q,   alu_en_b_d;
    logic [2:0]         alu_op_q,     alu_op_d;
    logic               rf_en_q,      rf_en_d;
    logic               rf_rw_q,      rf_rw_d;
    logic               imm_active_q, imm_active_d;
    logic               is_branch_q,  is_branch_d;
    logic [NREGS-1:0]   busy_q,       busy_d;
    logic [CNT_W-1:0]   stall_q,      stall_d;

    assign reads_src     = (in_type != TYPE_W'(4));
    assign writes_dst    = in_args[4] & in_args[5];
    assign in_imm_active = (in_type == TYPE_W'(1)) || (in_type == TYPE_W'(2)) ||
                           (in_type == TYPE_W'(3));
    assign in_is_branch  = (in_type == TYPE_W'(3)) || (in_type == TYPE_W'(4));

    // No wb bypass: a clear only becomes visible to the hazard check next cycle
    assign hazard   = in_valid & ((reads_src & busy_q[in_src]) | (writes_dst & busy_q[in_dst]));
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d      = valid_q;
        type_d       = type_q;
        src_d        = src_q;
        dst_d        = dst_q;
        imm_d        = imm_q;
        br_d         = br_q;
        alu_en_a_d   = alu_en_a_q;
        alu_en_b_d   = alu_en_b_q;
        alu_op_d     = alu_op_q;
        rf_en_d      = rf_en_q;
        rf_rw_d      = rf_rw_q;
        imm_active_d = imm_active_q;
        is_branch_d  = is_branch_q;
        busy_d       = busy_q;
        stall_d      = stall_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            type_d       = in_type;
            src_d        = in_src;
            dst_d        = in_dst;
            imm_d        = in_imm;
            br_d         = in_br;
            alu_en_a_d   = in_args[0];
            alu_en_b_d   = in_args[8];
            alu_op_d     = in_args[3:1];
            rf_en_d      = in_args[4];
            rf_rw_d      = in_args[5];
            imm_active_d = in_imm_active;
            is_branch_d  = in_is_branch;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // Set is applied after clear so a same-register collision leaves it busy
        if (wb_valid) begin
            busy_d[wb_reg] = 1'b0;
        end
        if (accept && writes_dst) begin
            busy_d[in_dst] = 1'b1;
        end

        if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            type_q       <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            imm_q        <= '0;
            br_q         <= '0;
            alu_en_a_q   <= 1'b0;
            alu_en_b_q   <= 1'b0;
            alu_op_q     <= '0;
            rf_en_q      <= 1'b0;
            rf_rw_q      <= 1'b0;
            imm_active_q <= 1'b0;
            is_branch_q  <= 1'b0;
            busy_q       <= '0;
            stall_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            type_q       <= type_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            imm_q        <= imm_d;
            br_q         <= br_d;
            alu_en_a_q   <= alu_en_a_d;
            alu_en_b_q   <= alu_en_b_d;
            alu_op_q     <= alu_op_d;
            rf_en_q      <= rf_en_d;
            rf_rw_q      <= rf_rw_d;
            imm_active_q <= imm_active_d;
            is_branch_q  <= is_branch_d;
            busy_q       <= busy_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_type       = type_q;
    assign out_src        = src_q;
    assign out_dst        = dst_q;
    assign out_imm        = imm_q;
    assign out_br_target  = br_q;
    assign out_alu_en_a   = alu_en_a_q;
    assign out_alu_en_b   = alu_en_b_q;
    assign out_alu_op     = alu_op_q;
    assign out_rf_en      = rf_en_q;
    assign out_rf_rw      = rf_rw_q;
    assign out_imm_active = imm_active_q;
    assign out_is_branch  = is_branch_q;
    assign busy_vec       = busy_q;
    assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_ucode_decode_stage.sv
// tb/tb_ucode_decode_stage.sv - directed and random checks of ucode_decode_stage against a reference model
module tb_ucode_decode_stage;

    localparam int MW = 39;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_minstr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_type;
    logic [4:0]    out_src;
    logic [4:0]    out_dst;
    logic [7:0]    out_imm;
    logic [7:0]    out_br_target;
    logic          out_alu_en_a;
    logic          out_alu_en_b;
    logic [2:0]    out_alu_op;
    logic          out_rf_en;
    logic          out_rf_rw;
    logic          out_imm_active;
    logic          out_is_branch;
    logic          wb_valid;
    logic [4:0]    wb_reg;
    logic [31:0]   busy_vec;
    logic [3:0]    stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit              busy_m [32];
    int              stall_m;
    bit              valid_m;
    logic [MW-1:0]   lat_m;

    ucode_decode_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_minstr(in_minstr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_type(out_type), .out_src(out_src),
        .out_dst(out_dst), .out_imm(out_imm), .out_br_target(out_br_target),
        .out_alu_en_a(out_alu_en_a), .out_alu_en_b(out_alu_en_b),
        .out_alu_op(out_alu_op), .out_rf_en(out_rf_en), .out_rf_rw(out_rf_rw),
        .out_imm_active(out_imm_active), .out_is_branch(out_is_branch),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .busy_vec(busy_vec),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mk(int t, int s, int d, int imm, int br, int args);
        longint unsigned w;
        w = (longint'(t) << 36) + (longint'(s) << 31) + (longint'(d) << 26) +
            (longint'(imm) << 18) + (longint'(br) << 10) + longint'(args);
        return w[MW-1:0];
    endfunction

    function automatic int fld(logic [MW-1:0] m, int lo, int w);
        longint unsigned mm;
        mm = 64'(m);
        return int'((mm >> lo) % (64'd1 << w));
    endfunction

    function automatic bit m_hazard();
        int t, s, d, a;
        bit rd, wr;
        t  = fld(in_minstr, 36, 3);
        s  = fld(in_minstr, 31, 5);
        d  = fld(in_minstr, 26, 5);
        a  = fld(in_minstr, 0, 10);
        rd = (t != 4);
        wr = ((a / 16) % 2 == 1) && ((a / 32) % 2 == 1);
        return in_valid && ((rd && busy_m[s]) || (wr && busy_m[d]));
    endfunction

    function automatic bit m_ready();
        return (!valid_m || out_ready) && !m_hazard() && !flush;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit hz, acc, wr;
        int a;
        if (rst) begin
            for (int i = 0; i < 32; i++) busy_m[i] = 0;
            stall_m = 0;
            valid_m = 0;
            lat_m   = '0;
        end else begin
            hz  = m_hazard();
            acc = in_valid && m_ready();
            a   = fld(in_minstr, 0, 10);
            wr  = ((a / 16) % 2 == 1) && ((a / 32) % 2 == 1);
            if (hz && !flush && stall_m < 15) stall_m++;
            if (wb_valid) busy_m[int'(wb_reg)] = 0;
            if (acc && wr) busy_m[fld(in_minstr, 26, 5)] = 1;
            if (flush) valid_m = 0;
            else if (acc) begin
                valid_m = 1;
                lat_m   = in_minstr;
            end else if (out_ready) valid_m = 0;
        end
    endtask

    task automatic check_outputs();
        int t, a;
        logic [31:0] bv;
        t = fld(lat_m, 36, 3);
        a = fld(lat_m, 0, 10);
        for (int i = 0; i < 32; i++) bv[i] = busy_m[i];
        chk("out_valid", 64'(out_valid), 64'(valid_m));
        chk("fields", {out_type, out_src, out_dst, out_imm, out_br_target},
            64'(fld(lat_m, 10, 29)));
        chk("alu_en_a", 64'(out_alu_en_a), 64'(a % 2));
        chk("alu_en_b", 64'(out_alu_en_b), 64'((a / 256) % 2));
        chk("alu_op", 64'(out_alu_op), 64'((a / 2) % 8));
        chk("rf_en_rw", 64'({out_rf_en, out_rf_rw}), 64'(((a / 16) % 2) * 2 + (a / 32) % 2));
        chk("imm_active", 64'(out_imm_active), 64'(t >= 1 && t <= 3));
        chk("is_branch", 64'(out_is_branch), 64'(t == 3 || t == 4));
        chk("busy_vec", 64'(busy_vec), 64'(bv));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    endtask

    // Inputs are applied at negedge; one call covers one clock edge
    task automatic cycle();
        #1;
        chk("in_ready", 64'(in_ready), 64'(m_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; in_minstr = '0; flush = 0;
        out_ready = 1; wb_valid = 0; wb_reg = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        cycle();
        chk("reset_busy", 64'(busy_vec), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);

        // Basic decode
        idle_inputs();
        in_valid = 1; in_minstr = mk(1, 3, 7, 'hA5, 'h12, 'h13F);
        cycle();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_alu_op", 64'(out_alu_op), 64'd7);
        chk("basic_flags", 64'({out_imm_active, out_is_branch, out_alu_en_a, out_alu_en_b,
            out_rf_en, out_rf_rw}), 64'b101111);
        chk("basic_busy7", 64'(busy_vec), 64'h80);

        // RAW stall on r7, then writeback releases it
        in_minstr = mk(0, 7, 2, 0, 0, 0);
        repeat (3) cycle();
        chk("raw_stall3", 64'(stall_cnt), 64'd3);
        wb_valid = 1; wb_reg = 7;
        cycle();
        chk("raw_busy_clr", 64'(busy_vec), 64'd0);
        chk("raw_stall4", 64'(stall_cnt), 64'd4);
        wb_valid = 0;
        cycle();
        chk("raw_accepted", 64'({out_valid, out_src}), 64'h27);

        // Back-pressure with no hazard
        out_ready = 0; in_minstr = mk(0, 1, 2, 'h11, 'h22, 0);
        repeat (5) cycle();
        chk("bp_stall_unchanged", 64'(stall_cnt), 64'd4);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_minstr = mk(2, i, i + 1, i * 3, i + 9, 'h1);
            cycle();
        end

        // Set/clear collision on r4
        wb_valid = 1; wb_reg = 4; in_minstr = mk(0, 1, 4, 0, 0, 'h30);
        cycle();
        chk("collide_busy4", 64'(busy_vec[4]), 64'd1);
        wb_valid = 0;

        // Flush while output valid
        flush = 1; in_minstr = mk(0, 1, 5, 0, 0, 0);
        cycle();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 0;

        // Reset in the middle of a stall on r4
        in_minstr = mk(0, 4, 5, 0, 0, 0);
        repeat (2) cycle();
        rst = 1;
        cycle();
        chk("rst_mid_stall", 64'({busy_vec, stall_cnt, out_valid}), 64'd0);
        rst = 0;

        // Saturation, then a branch that ignores its busy src
        in_minstr = mk(0, 0, 9, 0, 0, 'h30);
        cycle();
        in_minstr = mk(0, 9, 1, 0, 0, 0);
        repeat (20) cycle();
        chk("sat_15", 64'(stall_cnt), 64'd15);
        in_minstr = mk(4, 9, 1, 'h5A, 'h77, 0);
        cycle();
        chk("branch_nostall", 64'({out_valid, out_is_branch, out_br_target}), 64'h377);
        chk("sat_hold", 64'(stall_cnt), 64'd15);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_minstr = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 1023));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_reg    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
